// File: rtl/decoder_pkg.sv
// Shared types and helpers for the streaming binary-to-one-hot decoder.
package decoder_pkg;

  localparam int unsigned DefaultW = 2;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StFull  = 2'd1,
    StSkid  = 2'd2
  } state_e;

  // Widest supported decode; callers cast the result down to 2**W bits.
  function automatic logic [63:0] onehot_of(input logic [5:0] code);
    return 64'd1 << code;
  endfunction

endpackage

// File: rtl/decoder_if.sv
// Valid/ready input (code) and output (one-hot) streams; in_par exists only with DECODER_PARITY_EN.
interface decoder_if import decoder_pkg::*; #(
  parameter int unsigned W = DefaultW
) ();

  logic                in_valid;
  logic                in_ready;
  logic [W-1:0]        in_code;
`ifdef DECODER_PARITY_EN
  logic                in_par;
`endif
  logic                out_valid;
  logic                out_ready;
  logic [(1<<W)-1:0]   out_onehot;
  logic [W-1:0]        out_code;

  modport master (
    output in_valid, in_code,
`ifdef DECODER_PARITY_EN
    output in_par,
`endif
    input  in_ready,
    input  out_valid, out_onehot, out_code,
    output out_ready
  );

  modport slave (
    input  in_valid, in_code,
`ifdef DECODER_PARITY_EN
    input  in_par,
`endif
    output in_ready,
    output out_valid, out_onehot, out_code,
    input  out_ready
  );

endinterface

// File: rtl/decoder_skid.sv
// Two-register skid buffer (main drives the output, skid catches one beat under backpressure).
module decoder_skid import decoder_pkg::*; #(
  parameter int unsigned DataW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [DataW-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [DataW-1:0] out_data_o
);

  state_e           state_q, state_d;
  logic [DataW-1:0] main_q, main_d;
  logic [DataW-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic             acc, tx;

  assign acc         = in_valid_i && in_ready_q;
  assign tx          = (state_q != StEmpty) && out_ready_i;
  assign in_ready_o  = in_ready_q;
  assign out_valid_o = (state_q != StEmpty);
  assign out_data_o  = main_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (acc) begin
          main_d  = in_data_i;
          state_d = StFull;
        end
      end
      StFull: begin
        if (acc && !tx) begin
          skid_d  = in_data_i;
          state_d = StSkid;
        end else if (tx && !acc) begin
          state_d = StEmpty;
        end else if (acc && tx) begin
          main_d = in_data_i;
        end
      end
      StSkid: begin
        if (tx) begin
          main_d  = skid_q;
          state_d = StFull;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Registered ready: derived from where the buffer will be after this edge.
    in_ready_d = (state_d != StSkid);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule

// File: rtl/decoder_pipe.sv
// Streaming W-bit code to 2**W one-hot decoder with skid buffering and a transfer counter.
// Optional input parity check enabled by DECODER_PARITY_EN.
module decoder_pipe import decoder_pkg::*; #(
  parameter int unsigned W     = DefaultW,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  decoder_if.slave         bus,
  output logic             err,
  output logic [CNT_W-1:0] xfer_cnt
);

  localparam int unsigned OW    = 1 << W;
  localparam int unsigned DataW = W + OW;

  logic [OW-1:0]    onehot;
  logic [DataW-1:0] skid_in, skid_out;
  logic             skid_valid, skid_ready, out_valid;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign onehot  = OW'(onehot_of(6'(bus.in_code)));
  assign skid_in = {bus.in_code, onehot};

`ifdef DECODER_PARITY_EN
  logic par_ok, err_q, err_d;

  // Bad-parity beats complete the handshake but never reach the buffer.
  assign par_ok     = ~^{bus.in_code, bus.in_par};
  assign skid_valid = bus.in_valid && par_ok;
  assign err_d      = bus.in_valid && skid_ready && !par_ok;
  assign err        = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
`else
  assign skid_valid = bus.in_valid;
  assign err        = 1'b0;
`endif

  decoder_skid #(
    .DataW (DataW)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (skid_valid),
    .in_ready_o  (skid_ready),
    .in_data_i   (skid_in),
    .out_valid_o (out_valid),
    .out_ready_i (bus.out_ready),
    .out_data_o  (skid_out)
  );

  assign bus.in_ready   = skid_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_onehot = skid_out[OW-1:0];
  assign bus.out_code   = skid_out[OW +: W];

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && bus.out_ready) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_decoder_pipe.sv
// Directed self-checking bench for decoder_pipe (W = 2, CNT_W = 4); parity cases under DECODER_PARITY_EN.
module tb_decoder_pipe;

  logic       clk;
  logic       rst_n;
  logic       err;
  logic [3:0] xfer_cnt;
  int         n_checks;
  int         n_errors;

  decoder_if #(.W(2)) bus ();

  decoder_pipe #(
    .W     (2),
    .CNT_W (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .err      (err),
    .xfer_cnt (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] c);
    bus.in_valid = v;
    bus.in_code  = c;
`ifdef DECODER_PARITY_EN
    bus.in_par   = ^c;
`endif
  endtask

  initial begin
    logic [3:0] oh_tab [4];
    oh_tab[0] = 4'b0001;
    oh_tab[1] = 4'b0010;
    oh_tab[2] = 4'b0100;
    oh_tab[3] = 4'b1000;
    n_checks = 0;
    n_errors = 0;

    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 2'd0);
    step();
    step();
    check("rst_in_ready",  16'(bus.in_ready),   16'h0);
    check("rst_out_valid", 16'(bus.out_valid),  16'h0);
    check("rst_onehot",    16'(bus.out_onehot), 16'h0);
    check("rst_code",      16'(bus.out_code),   16'h0);
    check("rst_err",       16'(err),            16'h0);
    check("rst_cnt",       16'(xfer_cnt),       16'h0);

    rst_n = 1'b1;
    step();
    check("ready_rise", 16'(bus.in_ready), 16'h1);

    // Back-to-back codes 0..3, one-cycle latency.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i));
      step();
      check("b2b_valid",  16'(bus.out_valid),  16'h1);
      check("b2b_onehot", 16'(bus.out_onehot), 16'(oh_tab[i]));
      check("b2b_code",   16'(bus.out_code),   16'(i));
    end
    drive(1'b0, 2'd0);
    step();
    check("b2b_cnt",   16'(xfer_cnt),      16'd4);
    check("b2b_empty", 16'(bus.out_valid), 16'h0);

    // Stall: 2 held, 3 into skid, 1 refused.
    bus.out_ready = 1'b0;
    drive(1'b1, 2'd2);
    step();
    check("stall_oh0",  16'(bus.out_onehot), 16'b0100);
    check("stall_rdy0", 16'(bus.in_ready),   16'h1);
    drive(1'b1, 2'd3);
    step();
    check("stall_oh1",  16'(bus.out_onehot), 16'b0100);
    check("stall_rdy1", 16'(bus.in_ready),   16'h0);
    drive(1'b1, 2'd1);
    step();
    check("stall_oh2",   16'(bus.out_onehot), 16'b0100);
    check("stall_code2", 16'(bus.out_code),   16'd2);
    check("stall_rdy2",  16'(bus.in_ready),   16'h0);
    check("stall_cnt",   16'(xfer_cnt),       16'd4);
    bus.out_ready = 1'b1;
    step();
    check("rel_oh0",  16'(bus.out_onehot), 16'b1000);
    check("rel_rdy0", 16'(bus.in_ready),   16'h1);
    step();
    check("rel_oh1",  16'(bus.out_onehot), 16'b0010);
    drive(1'b0, 2'd0);
    step();
    check("rel_cnt",   16'(xfer_cnt),      16'd7);
    check("rel_empty", 16'(bus.out_valid), 16'h0);

    // Full throughput: 8 beats with simultaneous accept and transmit.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 2'((i + 1) % 4));
      step();
      check("tput_valid",  16'(bus.out_valid),  16'h1);
      check("tput_onehot", 16'(bus.out_onehot), 16'(oh_tab[(i + 1) % 4]));
    end
    drive(1'b0, 2'd0);
    step();
    check("tput_cnt", 16'(xfer_cnt), 16'd15);

    // Counter wrap: transfers 16 and 17.
    drive(1'b1, 2'd2);
    step();
    drive(1'b0, 2'd0);
    step();
    check("wrap_cnt0", 16'(xfer_cnt), 16'd0);
    drive(1'b1, 2'd1);
    step();
    drive(1'b0, 2'd0);
    step();
    check("wrap_cnt1", 16'(xfer_cnt), 16'd1);

    // Reset while in SKID.
    bus.out_ready = 1'b0;
    drive(1'b1, 2'd0);
    step();
    drive(1'b1, 2'd1);
    step();
    check("skid_rdy", 16'(bus.in_ready), 16'h0);
    rst_n = 1'b0;
    drive(1'b0, 2'd0);
    step();
    check("mid_rst_valid",  16'(bus.out_valid),  16'h0);
    check("mid_rst_onehot", 16'(bus.out_onehot), 16'h0);
    check("mid_rst_cnt",    16'(xfer_cnt),       16'h0);
    check("mid_rst_rdy",    16'(bus.in_ready),   16'h0);
    rst_n = 1'b1;
    step();
    check("post_rst_rdy",   16'(bus.in_ready),  16'h1);
    check("post_rst_valid", 16'(bus.out_valid), 16'h0);
    bus.out_ready = 1'b1;
    drive(1'b1, 2'd3);
    step();
    check("post_rst_oh",   16'(bus.out_onehot), 16'b1000);
    check("post_rst_code", 16'(bus.out_code),   16'd3);
    drive(1'b0, 2'd0);
    step();
    check("post_rst_cnt", 16'(xfer_cnt), 16'd1);
    check("no_err",       16'(err),      16'h0);

`ifdef DECODER_PARITY_EN
    // Bad parity: accepted, dropped, err for one cycle.
    drive(1'b1, 2'd3);
    bus.in_par = 1'b1;
    step();
    check("par_err",   16'(err),           16'h1);
    check("par_valid", 16'(bus.out_valid), 16'h0);
    check("par_cnt",   16'(xfer_cnt),      16'd1);
    drive(1'b0, 2'd0);
    step();
    check("par_err_off", 16'(err), 16'h0);
    drive(1'b1, 2'd3);
    bus.in_par = 1'b0;
    step();
    check("par_ok_oh",  16'(bus.out_onehot), 16'b1000);
    check("par_ok_err", 16'(err),            16'h0);
    drive(1'b0, 2'd0);
    step();
    check("par_ok_cnt", 16'(xfer_cnt), 16'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/decoder_pipe.md
# decoder_pipe

Streaming binary-to-one-hot decoder: the receive-side counterpart of the team's priority encoder. Accepts a W-bit code on a valid/ready input and presents the registered 2**W one-hot word on a valid/ready output. A two-entry skid buffer gives full throughput under backpressure. Sits downstream of the encoder path, wherever an encoded select must be expanded back into individual enables.

## Interface
- W, default 2: input code width; output width is 2**W (W = 1..6).
- CNT_W, default 16: width of the transfer counter.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block can accept; transfer occurs when in_valid && in_ready.
- in_code  in  W  binary code to decode.
- in_par  in  1  even-parity bit over in_code; present only with DECODER_PARITY_EN.
- out_valid  out  1  output beat present.
- out_ready  in  1  consumer accepts; transfer occurs when out_valid && out_ready.
- out_onehot  out  2**W  bit[in_code] = 1, all other bits 0.
- out_code  out  W  echo of the decoded code.
- err  out  1  one-cycle pulse on a parity-error drop; tied 0 without the macro.
- xfer_cnt  out  CNT_W  count of completed output transfers.

## Operation
- Storage: a main register (drives the outputs) and a skid register. Each register holds {code, onehot}.
- FSM states:
  - EMPTY: nothing held.
  - FULL: main valid.
  - SKID: main and skid valid.
- Signal derivation: out_valid = (state != EMPTY); in_ready = (state != SKID), registered.
- Transitions (acc = in transfer, tx = out transfer):
  - EMPTY: acc -> FULL, main loads the input.
  - FULL: acc && !tx -> SKID, skid loads. tx && !acc -> EMPTY. acc && tx -> FULL, main loads the new beat. Neither -> hold.
  - SKID: tx -> FULL, main takes the skid contents. Otherwise hold. No accept is possible (in_ready = 0).
- The onehot is computed combinationally from in_code before registering. Exactly one bit is set for every code value; there is no invalid code.
- Outputs are stable while out_valid && !out_ready. Beat order is strictly FIFO.
- xfer_cnt increments on each tx and wraps from 2**CNT_W-1 to 0.
- Reset: all state is cleared and held, whatever transfer is in flight.

## Timing
- Reset values (any edge with rst_n = 0): state EMPTY, in_ready 0, out_valid 0, out_onehot 0, out_code 0, err 0, xfer_cnt 0. Held beats are discarded.
- in_ready rises on the first edge with rst_n = 1.
- Latency: a beat accepted at edge t appears on out_valid/out_onehot at edge t+1 when the main register is free or is being drained at t.
- Throughput: one beat per cycle with out_ready held high.
- in_ready falls the edge after the skid register fills. It rises the edge after the skid drains.
- A simultaneous acc and tx in FULL causes no bubble.
- Reset asserted mid-stream: outputs are 0 on the next edge; no partial beat survives.

## Configuration
- Macro: DECODER_PARITY_EN.
- Defined:
  - The in_par port exists.
  - A beat with ^{in_code, in_par} != 0 is accepted (handshake honoured) but not stored.
  - err pulses high for exactly one cycle at t+1.
  - State and xfer_cnt are unchanged by the dropped beat.
- Undefined:
  - The in_par port is absent and err is constant 0.
  - Every accepted beat is decoded.

## Structure
- Package decoder_pkg holds:
  - A state enum (EMPTY/FULL/SKID).
  - A function onehot_of(code) returning 2**W bits.
  - A localparam for the default W.
- One natural sub-module, decoder_skid: the two-register, three-state buffer, parameterised on payload width. decoder_pipe wraps it with the decode logic, parity check and counter.

## Test plan
- Reset, then in_code = 0,1,2,3 back-to-back with out_ready = 1 (W = 2) -> out_onehot = 0001, 0010, 0100, 1000 on consecutive cycles, 1-cycle latency, xfer_cnt = 4.
- Stall:
  - Stimulus: out_ready = 0 while sending codes 2, 3, 1.
  - Holding: first beat holds at 0100; in_ready drops after the second beat; code 1 is not accepted.
  - Release: out_ready = 1 -> 0100, 1000, 0010 in order with no loss.
- Simultaneous acc and tx in FULL for 8 cycles -> no bubble; out_valid is continuously high.
- Assert rst_n = 0 for one cycle while in SKID -> the next edge shows out_valid = 0, out_onehot = 0, xfer_cnt = 0. Subsequent beats decode normally.
- Counter wrap with CNT_W = 4: 17 transfers -> xfer_cnt = 1.
- With DECODER_PARITY_EN: code 3 with in_par = 1 -> err pulses one cycle, no output beat. Code 3 with in_par = 0 -> 1000 is output and err stays 0.
